wordle_key_sender: RTL and testbench



---
 rtl/wordle_key_sender.sv | 153 +++++++++++++++
 tb/tb_wordle_key_sender.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/wordle_key_sender.sv
// Automated enter-key sequencer for the wordle game: encodes a 4-letter guess and replays clear/letters/compare/result presses.
// Optional build macro WORDLE_KEY_SENDER_SKIP_CLEAR_EN drops the leading clear press (sequence runs presses 1..6).
module wordle_key_sender #(
  parameter int SETUP_CYC = 2,
  parameter int PRESS_CYC = 4,
  parameter int GAP_CYC   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [19:0] letters,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [9:0]  switch_out,
  output logic        enter_out,
  output logic [2:0]  press_idx
);

  typedef enum logic [2:0] {IDLE, SETUP, PRESS, GAP, FINISH} state_t;

`ifdef WORDLE_KEY_SENDER_SKIP_CLEAR_EN
  localparam logic [2:0] FIRST_PRESS = 3'd1;
`else
  localparam logic [2:0] FIRST_PRESS = 3'd0;
`endif
  localparam logic [2:0] LAST_PRESS = 3'd6;

  localparam logic [7:0] SETUP_LD = 8'(SETUP_CYC - 1);
  localparam logic [7:0] PRESS_LD = 8'(PRESS_CYC - 1);
  localparam logic [7:0] GAP_LD   = 8'(GAP_CYC - 1);

  state_t      state;
  logic [7:0]  cnt;
  logic [19:0] letters_q;
  logic        start_ok;

  // Letter index i maps to a column (i%7, one-hot from bit 9 down) and a row group (i/7) in the low bits.
  function automatic logic [9:0] encode_letter(input logic [4:0] idx);
    logic [4:0] g;
    logic [4:0] p;
    logic [9:0] code;
    g         = idx / 5'd7;
    p         = idx - 5'(g * 5'd7);
    code      = '0;
    code[9:3] = 7'b1000000 >> p;
    case (g)
      5'd1:    code[2:0] = 3'b001;
      5'd2:    code[2:0] = 3'b010;
      5'd3:    code[2:0] = 3'b100;
      default: code[2:0] = 3'b000;
    endcase
    return code;
  endfunction

  function automatic logic [9:0] press_code(input logic [2:0] n, input logic [19:0] lt);
    case (n)
      3'd1:    return encode_letter(lt[19:15]);
      3'd2:    return encode_letter(lt[14:10]);
      3'd3:    return encode_letter(lt[9:5]);
      3'd4:    return encode_letter(lt[4:0]);
      default: return 10'd0;
    endcase
  endfunction

  function automatic logic letters_valid(input logic [19:0] lt);
    return (lt[19:15] <= 5'd25) && (lt[14:10] <= 5'd25) &&
           (lt[9:5]   <= 5'd25) && (lt[4:0]   <= 5'd25);
  endfunction

  assign start_ok = (state == IDLE) && start && letters_valid(letters);

  // Guess storage is pure data: captured once on acceptance, no reset needed.
  always_ff @(posedge clk) begin
    if (start_ok)
      letters_q <= letters;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= 8'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      switch_out <= 10'd0;
      enter_out  <= 1'b0;
      press_idx  <= 3'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (start_ok) begin
              state      <= SETUP;
              busy       <= 1'b1;
              err        <= 1'b0;
              press_idx  <= FIRST_PRESS;
              switch_out <= press_code(FIRST_PRESS, letters);
              cnt        <= SETUP_LD;
            end else begin
              err  <= 1'b1;
              done <= 1'b1;
            end
          end
        end
        SETUP: begin
          if (cnt == 8'd0) begin
            state     <= PRESS;
            enter_out <= 1'b1;
            cnt       <= PRESS_LD;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        PRESS: begin
          if (cnt == 8'd0) begin
            state     <= GAP;
            enter_out <= 1'b0;
            cnt       <= GAP_LD;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        GAP: begin
          if (cnt == 8'd0) begin
            if (press_idx == LAST_PRESS) begin
              state      <= FINISH;
              busy       <= 1'b0;
              done       <= 1'b1;
              switch_out <= 10'd0;
              press_idx  <= 3'd0;
            end else begin
              state      <= SETUP;
              press_idx  <= press_idx + 3'd1;
              switch_out <= press_code(press_idx + 3'd1, letters_q);
              cnt        <= SETUP_LD;
            end
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        FINISH: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wordle_key_sender.sv
// Directed bench for wordle_key_sender at default timing (2/4/4 -> 10-cycle presses).
module tb_wordle_key_sender;

`ifdef WORDLE_KEY_SENDER_SKIP_CLEAR_EN
  localparam int FIRST = 1;
`else
  localparam int FIRST = 0;
`endif
  localparam int NP   = 7 - FIRST;
  localparam int PLEN = 10;

  logic        clk;
  logic        reset;
  logic        start;
  logic [19:0] letters;
  logic        busy;
  logic        done;
  logic        err;
  logic [9:0]  switch_out;
  logic        enter_out;
  logic [2:0]  press_idx;

  int total = 0;
  int bad   = 0;

  wordle_key_sender #(.SETUP_CYC(2), .PRESS_CYC(4), .GAP_CYC(4)) dut (
    .clk(clk), .reset(reset), .start(start), .letters(letters),
    .busy(busy), .done(done), .err(err), .switch_out(switch_out),
    .enter_out(enter_out), .press_idx(press_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one accepted guess cycle by cycle; inject>0 pulses a competing start at that cycle.
  task automatic run_seq(input logic [19:0] lt, input logic [9:0] c1, input logic [9:0] c2,
                         input logic [9:0] c3, input logic [9:0] c4, input int inject);
    logic [9:0] codes [0:6];
    int k, ph, pn;
    codes[0] = 10'h000; codes[1] = c1; codes[2] = c2; codes[3] = c3;
    codes[4] = c4;      codes[5] = 10'h000; codes[6] = 10'h000;
    letters = lt;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    letters = 20'd0;
    for (int c = 1; c <= NP*PLEN + 2; c++) begin
      if (c <= NP*PLEN) begin
        k  = (c - 1) / PLEN;
        ph = (c - 1) % PLEN;
        pn = k + FIRST;
        check("seq_busy",  int'(busy),       1);
        check("seq_done",  int'(done),       0);
        check("seq_err",   int'(err),        0);
        check("seq_sw",    int'(switch_out), int'(codes[pn]));
        check("seq_enter", int'(enter_out),  (ph >= 2 && ph < 6) ? 1 : 0);
        check("seq_idx",   int'(press_idx),  pn);
      end else if (c == NP*PLEN + 1) begin
        check("fin_done",  int'(done),       1);
        check("fin_busy",  int'(busy),       0);
        check("fin_sw",    int'(switch_out), 0);
        check("fin_enter", int'(enter_out),  0);
        check("fin_idx",   int'(press_idx),  0);
      end else begin
        check("post_done", int'(done),       0);
        check("post_busy", int'(busy),       0);
      end
      if (inject > 0 && c == inject) begin
        start   = 1'b1;
        letters = {5'd25, 5'd25, 5'd25, 5'd25};
      end else if (inject > 0 && c == inject + 1) begin
        start   = 1'b0;
        letters = 20'd0;
      end
      tick();
    end
  endtask

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    letters = 20'd0;
    repeat (3) tick();
    check("rst_busy",  int'(busy),       0);
    check("rst_done",  int'(done),       0);
    check("rst_err",   int'(err),        0);
    check("rst_sw",    int'(switch_out), 0);
    check("rst_enter", int'(enter_out),  0);
    check("rst_idx",   int'(press_idx),  0);
    reset = 1'b0;
    tick();

    // B,I,T,S
    run_seq({5'd1, 5'd8, 5'd19, 5'd18}, 10'h100, 10'h101, 10'h012, 10'h022, 0);
    // A,G,H,Z
    run_seq({5'd0, 5'd6, 5'd7, 5'd25}, 10'h200, 10'h008, 10'h201, 10'h024, 0);

    // Rejected guess: letter3 = 26
    letters = {5'd1, 5'd8, 5'd26, 5'd18};
    start   = 1'b1;
    tick();
    start   = 1'b0;
    check("rej_done",  int'(done),      1);
    check("rej_err",   int'(err),       1);
    check("rej_busy",  int'(busy),      0);
    check("rej_enter", int'(enter_out), 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("rej_done_after",  int'(done),      0);
      check("rej_err_hold",    int'(err),       1);
      check("rej_busy_after",  int'(busy),      0);
      check("rej_enter_after", int'(enter_out), 0);
    end
    run_seq({5'd1, 5'd8, 5'd19, 5'd18}, 10'h100, 10'h101, 10'h012, 10'h022, 0);

    // Competing start during press 3 must be ignored
    run_seq({5'd1, 5'd8, 5'd19, 5'd18}, 10'h100, 10'h101, 10'h012, 10'h022, (3 - FIRST)*PLEN + 3);

    // Reset while press 2 is in its PRESS phase
    letters = {5'd1, 5'd8, 5'd19, 5'd18};
    start   = 1'b1;
    tick();
    start   = 1'b0;
    repeat ((2 - FIRST)*PLEN + 2) tick();
    check("mid_enter_pre", int'(enter_out), 1);
    check("mid_idx_pre",   int'(press_idx), 2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_enter", int'(enter_out),  0);
    check("mid_sw",    int'(switch_out), 0);
    check("mid_busy",  int'(busy),       0);
    check("mid_done",  int'(done),       0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("mid_done_after",  int'(done),      0);
      check("mid_enter_after", int'(enter_out), 0);
    end
    run_seq({5'd0, 5'd6, 5'd7, 5'd25}, 10'h200, 10'h008, 10'h201, 10'h024, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
